// File: rtl/rsa_ctrl_pkg.sv
// rtl/rsa_ctrl_pkg.sv - shared encodings for the RSA operand/DMA sequencer
package rsa_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RX_REQ  = 4'd1,
    ST_RX_WAIT = 4'd2,
    ST_COMPUTE = 4'd3,
    ST_TX_REQ  = 4'd4,
    ST_TX_WAIT = 4'd5,
    ST_DONE    = 4'd6,
    ST_ERROR   = 4'd7
  } state_e;

  localparam logic [31:0] CMD_IDLE   = 32'd0;
  localparam logic [31:0] CMD_FULL   = 32'd1;
  localparam logic [31:0] CMD_RECOMP = 32'd2;
  localparam logic [31:0] CMD_LOAD   = 32'd3;

  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_DMA     = 4'd1;
  localparam logic [3:0] ERR_TIMEOUT = 4'd2;
  localparam logic [3:0] ERR_NOOPS   = 4'd3;

  localparam int STAT_DONE      = 0;
  localparam int STAT_IDLE      = 1;
  localparam int STAT_ERROR     = 2;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_OPS_VALID = 4;
  localparam int STAT_IDX_LSB   = 8;
  localparam int STAT_ERR_LSB   = 12;
  localparam int STAT_CNT_LSB   = 16;

endpackage

// File: rtl/rsa_wait_timer.sv
// rtl/rsa_wait_timer.sv - wait-state cycle counter that flags expiry at TIMEOUT_CYC
module rsa_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (TIMEOUT_CYC == 0) begin : g_off
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q, count_d;

    // Count cycles spent in a guarded state; saturate at the last value
    always_comb begin
      count_d = count_q;
      if (clear_i) begin
        count_d = '0;
      end else if (enable_i && (count_q != LAST)) begin
        count_d = count_q + 1'b1;
      end
    end

    // Counter register
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    // Expiry on the TIMEOUT_CYC-th cycle spent in the state
    assign expired_o = enable_i && (count_q == LAST);
  end

endmodule

// File: rtl/rsa_multi_operand_ctrl.sv
// rtl/rsa_multi_operand_ctrl.sv - operand fetch, engine start and result write-back sequencer
module rsa_multi_operand_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int          DATA_W       = 1024,
  parameter int          NUM_OPERANDS = 5,
  parameter int unsigned TIMEOUT_CYC  = 2**20
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [31:0]                    command,
  input  logic [32*NUM_OPERANDS-1:0]     addr_in,
  input  logic [31:0]                    tx_addr,
  input  logic [DATA_W-1:0]              dma_rx_data,
  input  logic                           dma_done,
  input  logic                           dma_idle,
  input  logic                           dma_error,
  output logic                           dma_rx_start,
  output logic [31:0]                    dma_rx_address,
  output logic                           dma_tx_start,
  output logic [31:0]                    dma_tx_address,
  output logic [DATA_W-1:0]              dma_tx_data,
  output logic [DATA_W*NUM_OPERANDS-1:0] operands,
  output logic                           eng_start,
  input  logic                           eng_done,
  input  logic [DATA_W-1:0]              eng_result,
  output logic [31:0]                    status
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_OPERANDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        load_only_q, load_only_d;
  logic        ops_valid_q, ops_valid_d;
  logic [3:0]  err_code_q, err_code_d;
  logic [15:0] op_count_q, op_count_d;
  logic        rx_start_q, rx_start_d;
  logic        tx_start_q, tx_start_d;
  logic        eng_start_q, eng_start_d;
  logic [DATA_W-1:0] result_q;
  logic        bank_we;
  logic        result_we;
  logic        timer_en;
  logic        timer_clear;
  logic        timer_expired;

  assign timer_en = (state_q == ST_RX_REQ) || (state_q == ST_RX_WAIT) ||
                    (state_q == ST_COMPUTE) ||
                    (state_q == ST_TX_REQ) || (state_q == ST_TX_WAIT);
  // Any state change restarts the wait budget for the state being entered
  assign timer_clear = (state_d != state_q);

  rsa_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  // Next-state, strobe and bookkeeping decisions for the sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_only_d = load_only_q;
    ops_valid_d = ops_valid_q;
    err_code_d  = err_code_q;
    op_count_d  = op_count_q;
    rx_start_d  = 1'b0;
    tx_start_d  = 1'b0;
    eng_start_d = 1'b0;
    bank_we     = 1'b0;
    result_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((command == CMD_FULL) || (command == CMD_LOAD)) begin
          state_d     = ST_RX_REQ;
          idx_d       = 4'd0;
          load_only_d = (command == CMD_LOAD);
          err_code_d  = ERR_NONE;
        end else if (command == CMD_RECOMP) begin
          idx_d       = 4'd0;
          load_only_d = 1'b0;
          if (ops_valid_q) begin
            state_d     = ST_COMPUTE;
            eng_start_d = 1'b1;
            err_code_d  = ERR_NONE;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_NOOPS;
          end
        end
      end
      ST_RX_REQ: begin
        if (timer_expired) begin
          state_d     = ST_ERROR;
          err_code_d  = ERR_TIMEOUT;
          ops_valid_d = 1'b0;
        end else if (dma_idle) begin
          state_d    = ST_RX_WAIT;
          rx_start_d = 1'b1;
        end
      end
      ST_RX_WAIT: begin
        // idx is left pointing at the failed operand for diagnosis
        if (dma_error) begin
          state_d     = ST_ERROR;
          err_code_d  = ERR_DMA;
          ops_valid_d = 1'b0;
        end else if (timer_expired) begin
          state_d     = ST_ERROR;
          err_code_d  = ERR_TIMEOUT;
          ops_valid_d = 1'b0;
        end else if (dma_done) begin
          bank_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d       = 4'd0;
            ops_valid_d = 1'b1;
            if (load_only_q) begin
              state_d = ST_DONE;
            end else begin
              state_d     = ST_COMPUTE;
              eng_start_d = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_RX_REQ;
          end
        end
      end
      ST_COMPUTE: begin
        if (timer_expired) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else if (eng_done) begin
          result_we = 1'b1;
          state_d   = ST_TX_REQ;
        end
      end
      ST_TX_REQ: begin
        if (timer_expired) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else if (dma_idle) begin
          state_d    = ST_TX_WAIT;
          tx_start_d = 1'b1;
        end
      end
      ST_TX_WAIT: begin
        if (dma_error) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_DMA;
        end else if (timer_expired) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end else if (dma_done) begin
          state_d    = ST_DONE;
          op_count_d = op_count_q + 16'd1;
        end
      end
      ST_DONE, ST_ERROR: begin
        // Wait for the command to drop so a held command cannot re-trigger
        if (command == CMD_IDLE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, counters and one-cycle request strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      load_only_q <= 1'b0;
      ops_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      op_count_q  <= 16'd0;
      rx_start_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      load_only_q <= load_only_d;
      ops_valid_q <= ops_valid_d;
      err_code_q  <= err_code_d;
      op_count_q  <= op_count_d;
      rx_start_q  <= rx_start_d;
      tx_start_q  <= tx_start_d;
      eng_start_q <= eng_start_d;
    end
  end

  // Result register, captured when the engine reports completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
    end else if (result_we) begin
      result_q <= eng_result;
    end
  end

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_slot
    logic [DATA_W-1:0] slot_q;

    // Operand slot k, written only while idx selects it
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        slot_q <= '0;
      end else if (bank_we && (idx_q == 4'(k))) begin
        slot_q <= dma_rx_data;
      end
    end

    assign operands[DATA_W*k +: DATA_W] = slot_q;
  end

  // Status word assembled from the live sequencer registers
  always_comb begin
    status                           = '0;
    status[STAT_DONE]                = (state_q == ST_DONE);
    status[STAT_IDLE]                = (state_q == ST_IDLE);
    status[STAT_ERROR]               = (state_q == ST_ERROR);
    status[STAT_BUSY]                = (state_q != ST_DONE) && (state_q != ST_IDLE) &&
                                       (state_q != ST_ERROR);
    status[STAT_OPS_VALID]           = ops_valid_q;
    status[STAT_IDX_LSB +: 4]        = idx_q;
    status[STAT_ERR_LSB +: 4]        = err_code_q;
    status[STAT_CNT_LSB +: 16]       = op_count_q;
  end

  assign dma_rx_start   = rx_start_q;
  assign dma_rx_address = addr_in[32*idx_q +: 32];
  assign dma_tx_start   = tx_start_q;
  assign dma_tx_address = tx_addr;
  assign dma_tx_data    = result_q;
  assign eng_start      = eng_start_q;

endmodule

// File: tb/tb_rsa_multi_operand_ctrl.sv
// tb/tb_rsa_multi_operand_ctrl.sv - randomized self-checking bench for rsa_multi_operand_ctrl
module tb_rsa_multi_operand_ctrl;

  localparam int DW  = 64;
  localparam int NOP = 5;
  localparam int TO  = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [31:0]       command = 32'd0;
  logic [32*NOP-1:0] addr_in = '0;
  logic [31:0]       tx_addr = 32'd0;
  logic [DW-1:0]     dma_rx_data = '0;
  logic              dma_done = 1'b0;
  logic              dma_idle = 1'b1;
  logic              dma_error = 1'b0;
  logic              dma_rx_start;
  logic [31:0]       dma_rx_address;
  logic              dma_tx_start;
  logic [31:0]       dma_tx_address;
  logic [DW-1:0]     dma_tx_data;
  logic [DW*NOP-1:0] operands;
  logic              eng_start;
  logic              eng_done = 1'b0;
  logic [DW-1:0]     eng_result = '0;
  logic [31:0]       status;

  rsa_multi_operand_ctrl #(
    .DATA_W       (DW),
    .NUM_OPERANDS (NOP),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .command        (command),
    .addr_in        (addr_in),
    .tx_addr        (tx_addr),
    .dma_rx_data    (dma_rx_data),
    .dma_done       (dma_done),
    .dma_idle       (dma_idle),
    .dma_error      (dma_error),
    .dma_rx_start   (dma_rx_start),
    .dma_rx_address (dma_rx_address),
    .dma_tx_start   (dma_tx_start),
    .dma_tx_address (dma_tx_address),
    .dma_tx_data    (dma_tx_data),
    .operands       (operands),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .eng_result     (eng_result),
    .status         (status)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt = 0, tx_cnt = 0, eng_cnt = 0;

  logic [DW-1:0] m_bank [NOP];
  logic [31:0]   m_addr [NOP];
  logic [31:0]   m_tx_addr;
  bit            m_ops_valid;
  logic [3:0]    m_err;
  logic [3:0]    m_idx;
  logic [15:0]   m_op_count;
  logic [DW-1:0] next_data [NOP];
  logic [DW-1:0] next_result;
  int            fixed_lat;

  always @(negedge clk) begin
    if (resetn) begin
      if (dma_rx_start) rx_cnt++;
      if (dma_tx_start) tx_cnt++;
      if (eng_start)    eng_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // st: 0 idle, 1 done, 2 error
  function automatic logic [31:0] exp_status(input int st);
    return {m_op_count, m_err, m_idx, 3'b000, m_ops_valid, 1'b0, st == 2, st == 0, st == 1};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic wait_for(input int which, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((which == 0 && dma_rx_start) || (which == 1 && eng_start) || (which == 2 && dma_tx_start)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val({tag, "_seen"}, 64'(ok), 64'd1);
    if (!ok) finish_test();
  endtask

  task automatic dma_reply(input logic [DW-1:0] d, input bit err);
    int lat;
    lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    repeat (lat - 1) @(negedge clk);
    dma_done = 1'b1; dma_rx_data = d; dma_error = err;
    @(negedge clk);
    dma_done = 1'b0; dma_error = 1'b0;
  endtask

  task automatic eng_reply();
    int lat;
    lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    repeat (lat - 1) @(negedge clk);
    eng_done = 1'b1; eng_result = next_result;
    @(negedge clk);
    eng_done = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] cmd, input int err_slot, input bit hang, input int idle_low);
    int  n_rx_exp, n_eng_exp, n_tx_exp, final_st, k2;
    bit  aborted;
    n_rx_exp = 0; n_eng_exp = 0; n_tx_exp = 0; final_st = 1; aborted = 1'b0; k2 = 0;
    rx_cnt = 0; tx_cnt = 0; eng_cnt = 0;
    if (idle_low > 0) dma_idle = 1'b0;
    command = cmd;
    m_idx = 4'd0;
    m_err = 4'd0;
    if (cmd == 32'd2 && !m_ops_valid) begin
      m_err = 4'd3;
      final_st = 2;
      @(negedge clk);
    end else begin
      if (cmd != 32'd2) begin
        for (int k = 0; k < NOP; k++) begin
          if (k == 0 && idle_low > 0) begin
            repeat (idle_low) @(negedge clk);
            check_val("rx_held_off", 64'(rx_cnt), 64'd0);
            dma_idle = 1'b1;
          end
          wait_for(0, $sformatf("rx_start%0d", k));
          n_rx_exp++;
          check_val($sformatf("rx_addr%0d", k), 64'(dma_rx_address), 64'(m_addr[k]));
          if (k == 1) command = $urandom_range(1, 3);
          dma_reply(next_data[k], k == err_slot);
          if (k == err_slot) begin
            m_ops_valid = 1'b0;
            m_err = 4'd1;
            m_idx = 4'(k);
            final_st = 2;
            aborted = 1'b1;
            break;
          end
          m_bank[k] = next_data[k];
        end
        if (!aborted) m_ops_valid = 1'b1;
      end
      if (!aborted && cmd != 32'd3) begin
        wait_for(1, "eng_start");
        n_eng_exp = 1;
        if (hang) begin
          for (k2 = 1; k2 <= 40; k2++) begin
            @(negedge clk);
            if (status[2]) break;
          end
          check_val("timeout_cycles", 64'(k2), 64'(TO));
          m_err = 4'd2;
          final_st = 2;
        end else begin
          eng_reply();
          wait_for(2, "tx_start");
          n_tx_exp = 1;
          check_val("tx_addr", 64'(dma_tx_address), 64'(m_tx_addr));
          check_val("tx_data", dma_tx_data, next_result);
          dma_reply(rand_word(), 1'b0);
          m_op_count = m_op_count + 16'd1;
        end
      end
    end
    check_val("status_end", 64'(status), 64'(exp_status(final_st)));
    check_val("rx_count", 64'(rx_cnt), 64'(n_rx_exp));
    check_val("eng_count", 64'(eng_cnt), 64'(n_eng_exp));
    check_val("tx_count", 64'(tx_cnt), 64'(n_tx_exp));
    for (int k = 0; k < NOP; k++)
      check_val($sformatf("bank%0d", k), operands[DW*k +: DW], m_bank[k]);
    command = 32'd0;
    @(negedge clk);
    check_val("status_idle", 64'(status), 64'(exp_status(0)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected test to end");
    $fatal(1);
  end

  initial begin
    int ecmd, eslot;
    for (int k = 0; k < NOP; k++) begin
      m_addr[k] = $urandom;
      addr_in[32*k +: 32] = m_addr[k];
      m_bank[k] = '0;
    end
    m_tx_addr = $urandom;
    tx_addr = m_tx_addr;
    m_ops_valid = 1'b0; m_err = 4'd0; m_idx = 4'd0; m_op_count = 16'd0;
    fixed_lat = 0;

    @(negedge clk);
    check_val("reset_status", 64'(status), 64'h2);
    check_val("reset_rx_start", 64'(dma_rx_start), 64'd0);
    check_val("reset_eng_start", 64'(eng_start), 64'd0);
    check_val("reset_tx_data", dma_tx_data, 64'd0);
    for (int k = 0; k < NOP; k++)
      check_val($sformatf("reset_bank%0d", k), operands[DW*k +: DW], 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // stray completion while idle
    dma_done = 1'b1; dma_rx_data = rand_word();
    @(negedge clk);
    dma_done = 1'b0;
    @(negedge clk);
    check_val("stray_status", 64'(status), 64'(exp_status(0)));
    check_val("stray_bank0", operands[DW-1:0], m_bank[0]);

    // recompute with nothing cached
    do_op(32'd2, -1, 1'b0, 0);

    // reference full run
    for (int k = 0; k < NOP; k++) next_data[k] = DW'(32'h11 * (k + 1));
    next_result = DW'(32'hABC);
    fixed_lat = 3;
    do_op(32'd1, -1, 1'b0, 0);
    check_val("full_status_word", 64'(exp_status(1) & 32'hFFFF_FFFE | 32'h1), 64'h0001_0011);

    // recompute from cache
    fixed_lat = 0;
    next_result = rand_word();
    do_op(32'd2, -1, 1'b0, 0);
    check_val("op_count_after_recomp", 64'(status[31:16]), 64'd2);

    // DMA error on operand 2
    for (int k = 0; k < NOP; k++) next_data[k] = rand_word();
    do_op(32'd1, 2, 1'b0, 0);

    // DMA held busy for 10 cycles before the first read
    for (int k = 0; k < NOP; k++) next_data[k] = rand_word();
    next_result = rand_word();
    do_op(32'd1, -1, 1'b0, 10);

    // engine never answers
    for (int k = 0; k < NOP; k++) next_data[k] = rand_word();
    do_op(32'd1, -1, 1'b1, 0);

    // random mix of modes
    for (int it = 0; it < 8; it++) begin
      ecmd  = $urandom_range(1, 3);
      eslot = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NOP - 1) : -1;
      for (int k = 0; k < NOP; k++) next_data[k] = rand_word();
      next_result = rand_word();
      do_op(32'(ecmd), eslot, 1'b0, 0);
    end

    // asynchronous reset in the middle of a load
    command = 32'd1;
    wait_for(0, "rx_start_pre_reset");
    #2 resetn = 1'b0;
    #1;
    check_val("arst_rx_start", 64'(dma_rx_start), 64'd0);
    check_val("arst_status", 64'(status), 64'h2);
    check_val("arst_tx_data", dma_tx_data, 64'd0);
    for (int k = 0; k < NOP; k++)
      check_val($sformatf("arst_bank%0d", k), operands[DW*k +: DW], 64'd0);
    command = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < NOP; k++) m_bank[k] = '0;
    m_ops_valid = 1'b0; m_err = 4'd0; m_idx = 4'd0; m_op_count = 16'd0;
    @(negedge clk);
    for (int k = 0; k < NOP; k++) next_data[k] = rand_word();
    next_result = rand_word();
    do_op(32'd1, -1, 1'b0, 0);

    finish_test();
  end

endmodule
